// File: rtl/ifft_butterfly_pipe.sv
// Inverse radix-2 butterfly, two-stage valid/ready pipeline.
// Recovers a = (x+y)/2 and b = conj(w)*(x-y)/2 from a forward butterfly.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   input pair present
//   in_ready   pair accepted this cycle (combinational, independent of in_valid)
//   x, y, w    sum sample, difference sample, forward twiddle {re,im} Q1.15
//   out_valid  output pair present
//   out_ready  downstream accepts the output pair
//   a_out      recovered top operand {re,im} Q1.15
//   b_out      recovered bottom operand {re,im} Q1.15
//   count      output transfers since reset, wraps mod 2^16
//
// Build option:
//   IBFLY_ROUND_EN  round-half-up product scaling instead of truncation
module ifft_butterfly_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [15:0] count
);

    // Q2.30 product back to Q1.15
    function automatic logic [15:0] f_p(input logic signed [31:0] p);
        logic signed [31:0] t;
`ifdef IBFLY_ROUND_EN
        t = p + 32'sd16384;
`else
        t = p;
`endif
        return t[30:15];
    endfunction

    // Stage 1: 17-bit sum/difference, halved so it can never overflow
    logic [16:0] w_sr;
    logic [16:0] w_si;
    logic [16:0] w_dr;
    logic [16:0] w_di;

    assign w_sr = {x[31], x[31:16]} + {y[31], y[31:16]};
    assign w_si = {x[15], x[15:0]}  + {y[15], y[15:0]};
    assign w_dr = {x[31], x[31:16]} - {y[31], y[31:16]};
    assign w_di = {x[15], x[15:0]}  - {y[15], y[15:0]};

    logic        r_s1_valid;
    logic [15:0] r_sr;
    logic [15:0] r_si;
    logic [15:0] r_dr;
    logic [15:0] r_di;
    logic [31:0] r_w;

    logic        r_out_valid;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [15:0] r_count;

    logic        w_s1_adv;
    logic        w_out_xfer;

    assign w_s1_adv   = r_s1_valid && (!r_out_valid || out_ready);
    assign w_out_xfer = r_out_valid && out_ready;
    assign in_ready   = !r_s1_valid || w_s1_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_sr       <= 16'd0;
            r_si       <= 16'd0;
            r_dr       <= 16'd0;
            r_di       <= 16'd0;
            r_w        <= 32'd0;
        end else begin
            if (in_ready)
                r_s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                r_sr <= w_sr[16:1];
                r_si <= w_si[16:1];
                r_dr <= w_dr[16:1];
                r_di <= w_di[16:1];
                r_w  <= w;
            end
        end
    end

    // Stage 2: conj(w) * d
    logic signed [31:0] w_p_rr;
    logic signed [31:0] w_p_ii;
    logic signed [31:0] w_p_ir;
    logic signed [31:0] w_p_ri;
    logic        [15:0] w_br;
    logic        [15:0] w_bi;

    assign w_p_rr = $signed(r_dr) * $signed(r_w[31:16]);
    assign w_p_ii = $signed(r_di) * $signed(r_w[15:0]);
    assign w_p_ir = $signed(r_di) * $signed(r_w[31:16]);
    assign w_p_ri = $signed(r_dr) * $signed(r_w[15:0]);

    // Combining add/sub wraps mod 2^16
    assign w_br = f_p(w_p_rr) + f_p(w_p_ii);
    assign w_bi = f_p(w_p_ir) - f_p(w_p_ri);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_a         <= {r_sr, r_si};
            r_b         <= {w_br, w_bi};
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= 16'd0;
        else if (w_out_xfer)
            r_count <= r_count + 16'd1;
    end

    assign out_valid = r_out_valid;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign count     = r_count;

endmodule
